// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction prefetch FIFO between the MMU instruction port and the controlpath
// Ports: clk, rst_n (sync active-low) | MMU: instr_addr out, instr/wait_instr/instr_segv in
//        controlpath: instruction/instr_pc/instr_valid/instr_fault out, pc_inc/redirect/redirect_pc in
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr,
    input  logic        wait_instr,
    input  logic        instr_segv,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        instr_fault,
    input  logic        pc_inc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t state, state_nx;
    logic [31:0] fpc;
    logic [31:0] mem_word [DEPTH];
    logic [31:0] mem_pc [DEPTH];
    logic        mem_fault [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic cmp, pop;
    assign cmp = state == FETCH && count < FULL && !wait_instr && !redirect;
    assign pop = pc_inc && instr_valid && !redirect;
    assign instr_addr  = fpc;
    assign instr_valid = count != '0;
    assign instruction = instr_valid ? mem_word[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr] : 32'h0;
    assign instr_fault = instr_valid && mem_fault[rd_ptr];
    // A faulting fetch parks the stream until the controlpath redirects it.
    always_comb begin
        state_nx = state;
        if (redirect)
            state_nx = FETCH;
        else if (cmp && instr_segv)
            state_nx = HOLD;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            fpc    <= {redirect_pc[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (cmp) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!instr_segv)
                    fpc <= fpc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(cmp) - (AW+1)'(pop);
        end
    end
    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (cmp) begin
            mem_word[wr_ptr]  <= instr_segv ? 32'h0 : instr;
            mem_pc[wr_ptr]    <= fpc;
            mem_fault[wr_ptr] <= instr_segv;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr, instr, instruction, instr_pc, redirect_pc = 32'h0;
    logic        wait_instr = 1'b0, instr_segv = 1'b0, pc_inc = 1'b0, redirect = 1'b0;
    logic        instr_valid, instr_fault;
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } entry_t;
    entry_t exp_q[$];
    int checks = 0;
    int fails = 0;
    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr(instr),
        .wait_instr(wait_instr), .instr_segv(instr_segv), .instruction(instruction),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_fault(instr_fault),
        .pc_inc(pc_inc), .redirect(redirect), .redirect_pc(redirect_pc)
    );
    always #5 clk = ~clk;
    assign instr = instr_addr ^ 32'hA5A5_0000;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic exp_push(logic [31:0] pc, logic f);
        entry_t e;
        e.word  = f ? 32'h0 : pc ^ 32'hA5A5_0000;
        e.pc    = pc;
        e.fault = f;
        exp_q.push_back(e);
    endtask
    // Monitor: every consumed head entry must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && instr_valid && pc_inc && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_unexpected: got pc %h with no expected entry", instr_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("sb_word", instruction, e.word);
                check("sb_pc", instr_pc, e.pc);
                check("sb_fault", {31'h0, instr_fault}, {31'h0, e.fault});
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
    initial begin
        int a;
        tick();
        tick();
        check("rst_addr", instr_addr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_fault", {31'h0, instr_fault}, 32'h0);
        rst_n = 1'b1;
        // Stream into an empty queue with no consumer.
        for (int i = 0; i < 5; i++) begin
            tick();
            a = (i < 4) ? 4 * (i + 1) : 16;
            check("stream_addr", instr_addr, a);
            check("stream_valid", {31'h0, instr_valid}, 32'h1);
            check("stream_head_word", instruction, 32'hA5A5_0000);
            check("stream_head_pc", instr_pc, 32'h0);
        end
        check("stream_count", dut.count, 32'd4);
        // Flush, fetch two, then stall at fpc 8.
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        check("flush_valid", {31'h0, instr_valid}, 32'h0);
        check("flush_addr", instr_addr, 32'h0);
        for (int p = 0; p <= 20; p += 4)
            exp_push(p, 1'b0);
        tick();
        tick();
        check("pre_stall_addr", instr_addr, 32'h8);
        wait_instr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", instr_addr, 32'h8);
            check("stall_count", dut.count, 32'd2);
        end
        wait_instr = 1'b0;
        tick();
        check("unstall_count", dut.count, 32'd3);
        check("unstall_addr", instr_addr, 32'hC);
        // Pop one under stall to reach count 2, then push+pop together.
        wait_instr = 1'b1;
        pc_inc = 1'b1;
        tick();
        check("pop_only_count", dut.count, 32'd2);
        wait_instr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pp_count", dut.count, 32'd2);
            check("pp_head_pc", instr_pc, 8 + 4 * i);
        end
        pc_inc = 1'b0;
        check("pp_addr", instr_addr, 32'h20);
        // Fault at address 12.
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        exp_push(0, 1'b0);
        exp_push(4, 1'b0);
        exp_push(8, 1'b0);
        exp_push(12, 1'b1);
        tick();
        tick();
        tick();
        instr_segv = 1'b1;
        tick();
        instr_segv = 1'b0;
        check("fault_addr", instr_addr, 32'hC);
        check("fault_count", dut.count, 32'd4);
        pc_inc = 1'b1;
        for (int i = 0; i < 5; i++)
            tick();
        pc_inc = 1'b0;
        tick();
        tick();
        check("hold_valid", {31'h0, instr_valid}, 32'h0);
        check("hold_addr", instr_addr, 32'hC);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check("redir_addr", instr_addr, 32'h100);
        check("redir_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("redir_head_pc", instr_pc, 32'h100);
        check("redir_head_word", instruction, 32'hA5A5_0100);
        check("redir_next_addr", instr_addr, 32'h104);
        // Fill, then redirect colliding with pc_inc and a full queue.
        for (int i = 0; i < 4; i++)
            tick();
        check("full_addr", instr_addr, 32'h110);
        check("full_count", dut.count, 32'd4);
        redirect = 1'b1;
        pc_inc = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        pc_inc = 1'b0;
        check("coll_count", dut.count, 32'd0);
        check("coll_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("coll_head_pc", instr_pc, 32'h200);
        // Address wrap.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        exp_push(32'hFFFF_FFFC, 1'b0);
        exp_push(32'h0, 1'b0);
        tick();
        check("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", instr_addr, 32'h4);
        pc_inc = 1'b1;
        tick();
        check("wrap_pc_1", instr_pc, 32'h0);
        tick();
        check("wrap_pc_2", instr_pc, 32'h4);
        pc_inc = 1'b0;
        tick();
        tick();
        check("wrap_full_count", dut.count, 32'd4);
        check("wrap_full_addr", instr_addr, 32'h14);
        // Reset while full, colliding with a redirect.
        rst_n = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        check("rst_full_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_full_addr", instr_addr, 32'h0);
        check("rst_full_pc", instr_pc, 32'h0);
        redirect = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_head", instr_pc, 32'h0);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Instruction prefetch stage that sits between the MMU instruction port and the controlpath. It drives the fetch address into the MMU and absorbs wait_instr stalls. Returned words go into a small FIFO tagged with their PC and fault bit. The controlpath consumes the FIFO head with pc_inc and redirects the fetch stream on branches or traps.

Parameters:
DEPTH, 4, FIFO entries; must be a power of two and at least 2.
RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
instr_addr  output  32  fetch address to the MMU; always equals the internal fetch PC (fpc).
instr  input  32  MMU instruction word for instr_addr; valid when wait_instr=0.
wait_instr  input  1  MMU stall; 1 means the word for instr_addr is not ready this cycle.
instr_segv  input  1  MMU fault for instr_addr; qualified by wait_instr=0.
instruction  output  32  head instruction word to the controlpath.
instr_pc  output  32  PC of the head entry.
instr_valid  output  1  head entry present (queue not empty).
instr_fault  output  1  head entry is a faulting fetch; instruction is 0 for such an entry.
pc_inc  input  1  controlpath consumes the head this cycle.
redirect  input  1  flush the queue and restart fetch.
redirect_pc  input  32  new fetch address; bits [1:0] are forced to 0.

Behaviour:
- Storage: DEPTH entries of {word[31:0], pc[31:0], fault}, plus rd_ptr, wr_ptr and count (0..DEPTH).
- FSM states: FETCH and HOLD.
  - FETCH: fetching permitted.
  - HOLD: a faulting fetch has been queued; no further fetches until redirect.
- Fetch completion (cmp) = state==FETCH, count<DEPTH, wait_instr=0, redirect=0.
- Effect of cmp:
  - Push {instr, fpc, instr_segv}; if instr_segv=1, push word 0 instead of instr.
  - If instr_segv=0: fpc <= fpc+4, wrapping mod 2^32.
  - If instr_segv=1: fpc is held and state goes to HOLD.
- Latency: the word returned at edge N is visible at the head after edge N when the queue was empty. This is a 1-cycle fetch-to-issue latency; there is no combinational bypass from instr to instruction.
- Pop = pc_inc AND instr_valid AND NOT redirect. pc_inc while empty is ignored. When full, fpc is held and instr_addr stays stable.
- Push and pop in the same cycle: count unchanged and both pointers advance. Full with pop: no push that cycle, because cmp requires count<DEPTH before the edge.
- Redirect has priority over everything:
  - count, rd_ptr and wr_ptr are cleared.
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - state goes to FETCH.
  - Any MMU return in the same cycle is discarded.
  - A pc_inc in the same cycle is discarded.
  - The first fetch from the new PC can complete on the following cycle.
- Head outputs when empty: instruction=0, instr_pc=0, instr_fault=0, instr_valid=0.
- Head outputs when non-empty: the head fields are driven from registered storage.
- Reset (rst_n=0 at an edge) overrides redirect and all activity:
  - fpc=RESET_PC, state=FETCH, count=0, pointers=0.
  - All head outputs are 0 after the edge; instr_addr=RESET_PC after the edge.
  - Reset mid-stall or while full drops all entries. No partial state survives.
- Pointers wrap mod DEPTH. A counter overflow must be impossible: count never exceeds DEPTH and never goes below 0.
- The HOLD state is cleared only by redirect or reset. Popping the fault entry does not resume fetch.

Test Plan:
- Reset then stream: rst_n low 2 cycles, RESET_PC=0, wait_instr=0, MMU returns word = addr^32'hA5A5_0000, pc_inc held low.
  - Required: instr_addr steps 0,4,8,12 then holds at 16.
  - Required: count reaches 4 and instr_valid=1 from cycle 1.
  - Required: head = {32'hA5A5_0000, pc 0}.
- Stall: wait_instr=1 for 3 cycles starting with fpc=8, queue not full.
  - Required: instr_addr stays 8 and no push occurs.
  - Required: the push of pc 8 happens on the first cycle wait_instr=0.
- Simultaneous push and pop: queue at count 2 with pc_inc=1 and wait_instr=0 for 5 cycles.
  - Required: count stays 2 and instr_pc advances by 4 each cycle.
- Fault: instr_segv=1 at addr 12.
  - Required: an entry {word 0, pc 12, fault 1} is queued and fpc stays 12.
  - Required: no further pushes even after pc_inc drains the queue to empty.
  - Then redirect=1 with redirect_pc=32'h0000_0103. Required: fpc becomes 32'h100, state FETCH, and the next push is pc 32'h100.
- Redirect collision: redirect=1 with pc_inc=1, wait_instr=0 and a full queue.
  - Required: count=0 and instr_valid=0 next cycle, with nothing from the old stream queued.
- Wrap: set fpc to 32'hFFFF_FFFC via redirect.
  - Required: the next pushes carry pc FFFF_FFFC then 0000_0000.
  - Required: reset asserted while full clears instr_valid and sets instr_addr=RESET_PC.
